// File: rtl/bfp16_ws_col_seq_if.sv
// Buffer/column-side bundle of the BFP16 weight-stationary column sequencer.
// The master drives the weight/ifmap sources. The slave is the sequencer, which drives the column.
`timescale 1ns/1ps
interface bfp16_ws_col_seq_if #(
   parameter int DEPTH = 8
);
   logic                   w_valid;
   logic                   w_ready;
   logic [15:0]            w_data;
   logic                   x_valid;
   logic                   x_ready;
   logic [16*DEPTH-1:0]    x_data;
   logic                   pe_ctrl;
   logic [15:0]            pe_weight;
   logic [16*DEPTH-1:0]    pe_ifmap;
   logic                   res_valid;

   modport master (
      output w_valid, w_data, x_valid, x_data,
      input  w_ready, x_ready, pe_ctrl, pe_weight, pe_ifmap, res_valid
   );

   modport slave (
      input  w_valid, w_data, x_valid, x_data,
      output w_ready, x_ready, pe_ctrl, pe_weight, pe_ifmap, res_valid
   );
endinterface

// File: rtl/bfp16_ws_col_seq.sv
// Job sequencer for one weight-stationary BFP16 PE column: load weights, stream ifmaps, drain, done.
// Optional BFP16_SEQ_PERF_EN adds a saturating stall counter on stall_cnt.
`timescale 1ns/1ps
module bfp16_ws_col_seq #(
   parameter int DEPTH   = 8,
   parameter int OUT_LAT = 9,
   parameter int VCNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VCNT_W-1:0]  num_vec,
   output logic               busy,
   output logic               done,
   output logic [31:0]        stall_cnt,
   output logic [2:0]         state_dbg,
   bfp16_ws_col_seq_if.slave  bus
);
   localparam int WCNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [WCNT_W-1:0]     wcnt_q;
   logic [VCNT_W-1:0]     vcnt_q;
   logic [VCNT_W-1:0]     nv_q;
   logic [OUT_LAT:0]      vld_q;
   logic                  pe_ctrl_q;
   logic [15:0]           pe_weight_q;
   logic [16*DEPTH-1:0]   pe_ifmap_q;
   logic                  start_acc, w_acc, x_acc, w_last, x_last, pipe_empty;

   // Handshakes: a beat transfers on a rising edge where valid & ready are both high; ready is a
   // pure decode of the registered state, so it never depends on valid in the same cycle.
   assign bus.w_ready = (state_q == S_LOAD);
   assign bus.x_ready = (state_q == S_COMPUTE);

   assign start_acc  = (state_q == S_IDLE) && start;
   assign w_acc      = bus.w_valid && bus.w_ready;
   assign x_acc      = bus.x_valid && bus.x_ready;
   assign w_last     = (wcnt_q == WCNT_W'(DEPTH - 1));
   assign x_last     = (vcnt_q == nv_q - VCNT_W'(1));
   // Stage OUT_LAT leaves next cycle, so only the lower stages decide whether more results remain.
   assign pipe_empty = (vld_q[OUT_LAT-1:0] == '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = (num_vec == '0) ? S_FIN : S_LOAD;
         S_LOAD:    if (w_acc && w_last) state_d = S_COMPUTE;
         S_COMPUTE: if (x_acc && x_last) state_d = S_DRAIN;
         S_DRAIN:   if (pipe_empty) state_d = S_FIN;
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         vcnt_q  <= '0;
         nv_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            wcnt_q <= '0;
            vcnt_q <= '0;
            nv_q   <= num_vec;
         end else begin
            if (w_acc) wcnt_q <= w_last ? '0 : wcnt_q + WCNT_W'(1);
            if (x_acc) vcnt_q <= vcnt_q + VCNT_W'(1);
         end
      end
   end

   // Column drive: shift only on a real weight beat; zero ifmap whenever no vector is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_ctrl_q   <= 1'b1;
         pe_weight_q <= '0;
         pe_ifmap_q  <= '0;
         vld_q       <= '0;
      end else begin
         pe_ctrl_q  <= !w_acc;
         if (w_acc) pe_weight_q <= bus.w_data;
         pe_ifmap_q <= x_acc ? bus.x_data : '0;
         vld_q      <= {vld_q[OUT_LAT-1:0], x_acc};
      end
   end

   assign bus.pe_ctrl   = pe_ctrl_q;
   assign bus.pe_weight = pe_weight_q;
   assign bus.pe_ifmap  = pe_ifmap_q;
   assign bus.res_valid = vld_q[OUT_LAT];
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FIN);
   assign state_dbg     = state_q;

`ifdef BFP16_SEQ_PERF_EN
   logic [31:0] stall_q;
   logic        stall_hit;

   assign stall_hit = ((state_q == S_LOAD) && !bus.w_valid) ||
                      ((state_q == S_COMPUTE) && !bus.x_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          stall_q <= '0;
      else if (start_acc)                stall_q <= '0;
      else if (stall_hit && !(&stall_q)) stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_bfp16_ws_col_seq.sv
// Directed bench for bfp16_ws_col_seq: drivers push expected weights, ifmaps and result/done cycles;
// a negedge monitor pops and compares them whenever the DUT presents a beat.
`timescale 1ns/1ps
module tb_bfp16_ws_col_seq;
   localparam int DEPTH   = 8;
   localparam int OUT_LAT = 9;
   localparam int VCNT_W  = 16;
   localparam int XW      = 16*DEPTH;

   logic               clk;
   logic               rst;
   logic               start;
   logic [VCNT_W-1:0]  num_vec;
   logic               busy;
   logic               done;
   logic [31:0]        stall_cnt;
   logic [2:0]         state_dbg;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int pe0_cnt = 0;
   int first_pe0_cyc = 0;
   int last_done_cyc = 0;

   logic [15:0] w_exp_q[$];
   logic [XW-1:0] x_exp_q[$];
   int rv_exp_q[$];
   int done_exp_q[$];

   bfp16_ws_col_seq_if #(.DEPTH(DEPTH)) bus ();

   bfp16_ws_col_seq #(.DEPTH(DEPTH), .OUT_LAT(OUT_LAT), .VCNT_W(VCNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
      .stall_cnt(stall_cnt), .state_dbg(state_dbg), .bus(bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (bus.pe_ctrl == 1'b0) begin
            if (pe0_cnt == 0) first_pe0_cyc = cyc;
            pe0_cnt++;
            if (w_exp_q.size() == 0) flag("pe_weight_extra");
            else chk("pe_weight", XW'(bus.pe_weight), XW'(w_exp_q.pop_front()));
         end
         if (bus.pe_ifmap != '0) begin
            if (x_exp_q.size() == 0) flag("pe_ifmap_extra");
            else chk("pe_ifmap", bus.pe_ifmap, x_exp_q.pop_front());
         end
         if (bus.res_valid) begin
            if (rv_exp_q.size() == 0) flag("res_valid_extra");
            else chk("res_valid_cycle", XW'(cyc), XW'(rv_exp_q.pop_front()));
         end
         if (done) begin
            last_done_cyc = cyc;
            if (done_exp_q.size() == 0) flag("done_extra");
            else chk("done_cycle", XW'(cyc), XW'(done_exp_q.pop_front()));
         end
      end
   end

   // driver: one complete job; gap bits insert one idle source cycle before that beat/vector
   task automatic drive_job(input int nv, input int w_gap, input int x_gap,
                            input bit poke_load, input bit poke_done, output int s_cyc);
      int exp_stall;
      int exp_done;
      int last_acc;
      int guard;
      logic [15:0] wd;
      logic [XW-1:0] xd;
      exp_stall = 0;
      last_acc  = 0;
      @(posedge clk); #1;
      start   = 1'b1;
      num_vec = VCNT_W'(nv);
      s_cyc   = cyc;
      pe0_cnt = 0;
      @(posedge clk); #1;
      start = 1'b0;
      if (nv == 0) begin
         chk("nv0_w_ready", XW'(bus.w_ready), XW'(0));
         chk("nv0_x_ready", XW'(bus.x_ready), XW'(0));
         chk("nv0_pe_ctrl", XW'(bus.pe_ctrl), XW'(1));
         exp_done = s_cyc + 1;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_gap[i]) begin
               bus.w_valid = 1'b0;
               exp_stall++;
               @(posedge clk); #1;
            end
            wd = 16'(16'hA000 + s_cyc * 16 + i);
            bus.w_valid = 1'b1;
            bus.w_data  = wd;
            if (poke_load && i == 2) begin
               start   = 1'b1;
               num_vec = VCNT_W'(nv + 3);
            end
            guard = 0;
            while (!bus.w_ready && guard < 20) begin
               @(posedge clk); #1;
               guard++;
            end
            chk("w_ready", XW'(bus.w_ready), XW'(1));
            w_exp_q.push_back(wd);
            @(posedge clk); #1;
            start   = 1'b0;
            num_vec = VCNT_W'(nv);
         end
         bus.w_valid = 1'b0;
         for (int v = 0; v < nv; v++) begin
            if (v < 32 && x_gap[v]) begin
               bus.x_valid = 1'b0;
               exp_stall++;
               @(posedge clk); #1;
            end
            for (int l = 0; l < DEPTH; l++) xd[16*l +: 16] = 16'((v + 1) * 256 + l + 1);
            bus.x_valid = 1'b1;
            bus.x_data  = xd;
            guard = 0;
            while (!bus.x_ready && guard < 20) begin
               @(posedge clk); #1;
               guard++;
            end
            chk("x_ready", XW'(bus.x_ready), XW'(1));
            x_exp_q.push_back(xd);
            rv_exp_q.push_back(cyc + 1 + OUT_LAT);
            last_acc = cyc;
            @(posedge clk); #1;
         end
         bus.x_valid = 1'b0;
         bus.x_data  = '0;
         exp_done = last_acc + OUT_LAT + 2;
      end
      done_exp_q.push_back(exp_done);
      while (cyc < exp_done) begin
         @(posedge clk); #1;
      end
      chk("busy_in_done_cycle", XW'(busy), XW'(1));
      if (poke_done) begin
         start   = 1'b1;
         num_vec = VCNT_W'(nv + 1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_done", XW'(busy), XW'(0));
      chk("state_idle_after_done", XW'(state_dbg), XW'(0));
`ifdef BFP16_SEQ_PERF_EN
      chk("stall_cnt", XW'(stall_cnt), XW'(exp_stall));
`else
      chk("stall_cnt", XW'(stall_cnt), XW'(0));
`endif
      chk("pe_ctrl0_cycles", XW'(pe0_cnt), XW'((nv > 0) ? DEPTH : 0));
      chk("job_queues_drained", XW'(w_exp_q.size() + x_exp_q.size() + rv_exp_q.size() + done_exp_q.size()), XW'(0));
   endtask

   initial begin
      int s;
      logic [XW-1:0] v0;
      logic [XW-1:0] v1;
      rst = 1'b0;
      start = 1'b0;
      num_vec = '0;
      bus.w_valid = 1'b0;
      bus.w_data  = '0;
      bus.x_valid = 1'b0;
      bus.x_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", XW'(busy), XW'(0));
      chk("rst_pe_ctrl", XW'(bus.pe_ctrl), XW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset_busy", XW'(busy), XW'(0));
      chk("reset_done", XW'(done), XW'(0));
      chk("reset_pe_ctrl", XW'(bus.pe_ctrl), XW'(1));
      chk("reset_pe_weight", XW'(bus.pe_weight), XW'(0));
      chk("reset_pe_ifmap", bus.pe_ifmap, XW'(0));
      chk("reset_res_valid", XW'(bus.res_valid), XW'(0));
      chk("reset_stall_cnt", XW'(stall_cnt), XW'(0));
      chk("reset_w_ready", XW'(bus.w_ready), XW'(0));
      chk("reset_x_ready", XW'(bus.x_ready), XW'(0));
      chk("reset_state", XW'(state_dbg), XW'(0));

      // back-to-back job: weights on cycles 2..9, done on cycle 23 relative to start
      drive_job(4, 0, 0, 1'b0, 1'b0, s);
      chk("t2_first_weight_rel", XW'(first_pe0_cyc - s), XW'(2));
      chk("t2_done_rel", XW'(last_done_cyc - s), XW'(23));

      // weight source drops before beats 3 and 6
      drive_job(2, 32'h48, 0, 1'b0, 1'b0, s);

      // ifmap source toggling 1,0,1,0,1
      drive_job(3, 0, 32'h6, 1'b0, 1'b0, s);

      // empty job
      drive_job(0, 0, 0, 1'b0, 1'b0, s);
      chk("nv0_done_rel", XW'(last_done_cyc - s), XW'(1));

      // start re-pulsed during LOAD and on the done cycle
      drive_job(2, 0, 0, 1'b1, 1'b1, s);

      // async reset in the middle of COMPUTE
      @(posedge clk); #1;
      start = 1'b1;
      num_vec = VCNT_W'(4);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.w_valid = 1'b1;
         bus.w_data  = 16'(16'h5A00 + i);
         chk("rst_job_w_ready", XW'(bus.w_ready), XW'(1));
         w_exp_q.push_back(16'(16'h5A00 + i));
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
      for (int l = 0; l < DEPTH; l++) begin
         v0[16*l +: 16] = 16'(16'h0700 + l);
         v1[16*l +: 16] = 16'(16'h0800 + l);
      end
      bus.x_valid = 1'b1;
      bus.x_data  = v0;
      chk("rst_job_x_ready", XW'(bus.x_ready), XW'(1));
      x_exp_q.push_back(v0);
      @(posedge clk); #1;
      bus.x_data = v1;
      @(posedge clk); #1;
      bus.x_valid = 1'b0;
      bus.x_data  = '0;
      rst = 1'b0;
      #1;
      chk("midrst_busy", XW'(busy), XW'(0));
      chk("midrst_res_valid", XW'(bus.res_valid), XW'(0));
      chk("midrst_pe_ctrl", XW'(bus.pe_ctrl), XW'(1));
      chk("midrst_pe_ifmap", bus.pe_ifmap, XW'(0));
      chk("midrst_state", XW'(state_dbg), XW'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (OUT_LAT + 3) @(posedge clk);
      #1;
      chk("post_rst_state", XW'(state_dbg), XW'(0));
      chk("post_rst_busy", XW'(busy), XW'(0));
      chk("post_rst_queues", XW'(w_exp_q.size() + x_exp_q.size() + rv_exp_q.size() + done_exp_q.size()), XW'(0));

      // recovery job after the abandoned one
      drive_job(1, 0, 0, 1'b0, 1'b0, s);

      repeat (OUT_LAT + 3) @(posedge clk);
      #1;
      chk("final_queues", XW'(w_exp_q.size() + x_exp_q.size() + rv_exp_q.size() + done_exp_q.size()), XW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
